lzs_token_parser: RTL

LZS_TOKEN_PARSER -- requirements
Module: lzs_token_parser

---
 rtl/lzs_pkg.sv | 31 +++
 rtl/lzs_tok_slot.sv | 41 ++++
 rtl/lzs_token_parser.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lzs_pkg.sv
// Shared encodings for the LZS token parser: token kinds, FSM states and the
// fixed bit patterns / length bases of the LZS length code.
package lzs_pkg;

  typedef enum logic [1:0] {
    TOK_LIT  = 2'd0,
    TOK_COPY = 2'd1,
    TOK_END  = 2'd2,
    TOK_ERR  = 2'd3
  } tok_type_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PROC = 3'd1,
    LEN1 = 3'd2,
    LEN2 = 3'd3,
    LENX = 3'd4,
    EMIT = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam logic [8:0] END_MARKER = 9'b110000000;

  // Length code: 2-bit groups start at 2 and 5, the nibble run starts at 8
  // and every all-ones nibble adds 15.
  localparam int LEN_BASE_1 = 2;
  localparam int LEN_BASE_2 = 5;
  localparam int LEN_BASE_X = 8;
  localparam int LEN_EXT    = 15;

endpackage

// File: rtl/lzs_tok_slot.sv
// One-entry token register. Fields change only on load, so they stay stable
// for as long as valid is high and ready is low.
module lzs_tok_slot #(
  parameter int OFF_W = 11,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       load_type,
  input  logic [7:0]       load_lit,
  input  logic [OFF_W-1:0] load_off,
  input  logic [LEN_W-1:0] load_len,
  input  logic             ready,
  output logic             valid,
  output logic [1:0]       tok_type,
  output logic [7:0]       tok_lit,
  output logic [OFF_W-1:0] tok_off,
  output logic [LEN_W-1:0] tok_len
);

  // The parent only loads when the slot is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      tok_type <= 2'd0;
      tok_lit  <= 8'd0;
      tok_off  <= '0;
      tok_len  <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      tok_type <= load_type;
      tok_lit  <= load_lit;
      tok_off  <= load_off;
      tok_len  <= load_len;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/lzs_token_parser.sv
// LZS bitstream token parser: peeks MSB-aligned stream bits, decodes literal,
// copy, end and error tokens, and hands them out through a one-entry slot.
module lzs_token_parser
  import lzs_pkg::*;
#(
  parameter int  OFF_LONG_W  = 11,
  parameter int  OFF_SHORT_W = 7,
  parameter int  LEN_W       = 16,
  localparam int PEEK_W      = OFF_LONG_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PEEK_W-1:0]     stream_data,
  input  logic                  stream_valid,
  output logic [3:0]            stream_width,
  output logic                  stream_ack,
  output logic                  stream_align,
  output logic [1:0]            tok_type,
  output logic [7:0]            tok_lit,
  output logic [OFF_LONG_W-1:0] tok_off,
  output logic [LEN_W-1:0]      tok_len,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  if (PEEK_W > 15) begin : g_peek_too_wide
    $error("lzs_token_parser: PEEK_W = OFF_LONG_W+2 must not exceed 15");
  end

  // Handshakes: a token transfers on a cycle where tok_valid && tok_ready;
  // stream bits are consumed on a cycle where stream_ack is high, and
  // stream_ack only rises when stream_valid is high and the slot can take a
  // new token (empty, or draining this same cycle).
  state_e                state, state_nx;
  logic [OFF_LONG_W-1:0] off_q, off_nx;
  logic [LEN_W-1:0]      len_q, len_nx;
  logic [LEN_W-1:0]      acc_q, acc_nx;
  logic [LEN_W:0]        acc_sum;
  logic                  slot_free, avail;
  logic [1:0]            top2;
  logic [3:0]            nib;

  logic                  ld;
  tok_type_e             ld_type;
  logic [7:0]            ld_lit;
  logic [OFF_LONG_W-1:0] ld_off;
  logic [LEN_W-1:0]      ld_len;

  assign slot_free = !tok_valid || tok_ready;
  assign avail     = stream_valid && slot_free;
  assign top2      = stream_data[PEEK_W-1 -: 2];
  assign nib       = stream_data[PEEK_W-1 -: 4];
  // The extra top bit flags a length that no longer fits in LEN_W.
  assign acc_sum   = {1'b0, acc_q} + (LEN_W+1)'(nib);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      off_q <= '0;
      len_q <= '0;
      acc_q <= '0;
    end else begin
      state <= state_nx;
      off_q <= off_nx;
      len_q <= len_nx;
      acc_q <= acc_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    off_nx       = off_q;
    len_nx       = len_q;
    acc_nx       = acc_q;
    stream_ack   = 1'b0;
    stream_width = 4'd0;
    stream_align = 1'b0;
    ld           = 1'b0;
    ld_type      = TOK_LIT;
    ld_lit       = 8'd0;
    ld_off       = '0;
    ld_len       = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = PROC;
      end
      PROC: begin
        if (avail) begin
          stream_ack = 1'b1;
          if (!stream_data[PEEK_W-1]) begin
            stream_width = 4'd9;
            ld           = 1'b1;
            ld_type      = TOK_LIT;
            ld_lit       = stream_data[PEEK_W-2 -: 8];
          end else if (stream_data[PEEK_W-1 -: 9] == END_MARKER) begin
            stream_width = 4'd9;
            stream_align = 1'b1;
            ld           = 1'b1;
            ld_type      = TOK_END;
            state_nx     = DONE;
          end else if (stream_data[PEEK_W-2]) begin
            stream_width = 4'(OFF_SHORT_W + 2);
            off_nx       = OFF_LONG_W'(stream_data[PEEK_W-3 -: OFF_SHORT_W]);
            state_nx     = LEN1;
          end else begin
            stream_width = 4'(OFF_LONG_W + 2);
            if (stream_data[OFF_LONG_W-1:0] == '0) begin
              ld       = 1'b1;
              ld_type  = TOK_ERR;
              state_nx = DONE;
            end else begin
              off_nx   = stream_data[OFF_LONG_W-1:0];
              state_nx = LEN1;
            end
          end
        end
      end
      LEN1: begin
        if (avail) begin
          stream_ack   = 1'b1;
          stream_width = 4'd2;
          if (top2 == 2'b11) begin
            state_nx = LEN2;
          end else begin
            len_nx   = LEN_W'(LEN_BASE_1) + LEN_W'(top2);
            state_nx = EMIT;
          end
        end
      end
      LEN2: begin
        if (avail) begin
          stream_ack   = 1'b1;
          stream_width = 4'd2;
          if (top2 == 2'b11) begin
            acc_nx   = LEN_W'(LEN_BASE_X);
            state_nx = LENX;
          end else begin
            len_nx   = LEN_W'(LEN_BASE_2) + LEN_W'(top2);
            state_nx = EMIT;
          end
        end
      end
      LENX: begin
        if (avail) begin
          stream_ack   = 1'b1;
          stream_width = 4'd4;
          // Any sum that leaves LEN_W (including a terminating nibble) is an error.
          if (acc_sum[LEN_W]) begin
            ld       = 1'b1;
            ld_type  = TOK_ERR;
            acc_nx   = '0;
            state_nx = DONE;
          end else if (nib == 4'(LEN_EXT)) begin
            acc_nx = acc_sum[LEN_W-1:0];
          end else begin
            len_nx   = acc_sum[LEN_W-1:0];
            acc_nx   = '0;
            state_nx = EMIT;
          end
        end
      end
      EMIT: begin
        if (slot_free) begin
          ld       = 1'b1;
          ld_type  = TOK_COPY;
          ld_off   = off_q;
          ld_len   = len_q;
          state_nx = PROC;
        end
      end
      DONE: begin
        if (start) state_nx = PROC;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  lzs_tok_slot #(
    .OFF_W (OFF_LONG_W),
    .LEN_W (LEN_W)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_type (ld_type),
    .load_lit  (ld_lit),
    .load_off  (ld_off),
    .load_len  (ld_len),
    .ready     (tok_ready),
    .valid     (tok_valid),
    .tok_type  (tok_type),
    .tok_lit   (tok_lit),
    .tok_off   (tok_off),
    .tok_len   (tok_len)
  );

endmodule
